// File: rtl/unified_memory_responder.sv
// Shared single-port word memory serving an instruction (read-only) port and a data port,
// round-robin arbitrated, fixed LATENCY. Optional perf counters behind MEMORY_RESPONDER_PERF_EN.
module unified_memory_responder #(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_request,
  input  logic [31:0] i_address,
  output logic [31:0] i_read_data,
  output logic        i_ready,
  input  logic        d_request,
  input  logic [31:0] d_address,
  input  logic        d_write_enable,
  input  logic [3:0]  d_byte_enable,
  input  logic [31:0] d_write_data,
  output logic [31:0] d_read_data,
  output logic        d_ready,
  output logic [31:0] perf_i_count,
  output logic [31:0] perf_d_count,
  output logic [31:0] perf_busy_cycles
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // state   | meaning
  // IDLE    | waiting for a request, arbitrates and latches on accept
  // WAIT    | latency countdown for the latched transaction
  // RESPOND | ready pulse for the granted port, then back to IDLE
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  state_t        state;
  logic [2:0]    count;
  logic          grant_d;
  logic          last_d;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   cur_word;
  logic [31:0]   merged;
  logic          pick_d;
  logic          unused_addr_bits;

  // Upper address bits wrap and byte offset is ignored.
  assign unused_addr_bits = ^{i_address[31:AW+2], i_address[1:0],
                              d_address[31:AW+2], d_address[1:0]};

  // On a tie, D wins only if I was granted last.
  assign pick_d = d_request && (!i_request || !last_d);

  always_comb begin
    cur_word = mem[addr_q];
    merged   = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (we_q && be_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      i_ready     <= 1'b0;
      d_ready     <= 1'b0;
      i_read_data <= '0;
      d_read_data <= '0;
      last_d      <= 1'b1;
      grant_d     <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_request || d_request) begin
            grant_d <= pick_d;
            last_d  <= pick_d;
            addr_q  <= pick_d ? d_address[AW+1:2] : i_address[AW+1:2];
            we_q    <= pick_d && d_write_enable;
            be_q    <= d_byte_enable;
            wdata_q <= d_write_data;
            count   <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (count == 3'(LATENCY - 1)) begin
            state <= RESPOND;
            if (grant_d) begin
              d_ready     <= 1'b1;
              d_read_data <= merged;
              if (we_q) mem[addr_q] <= merged;
            end else begin
              i_ready     <= 1'b1;
              i_read_data <= cur_word;
            end
          end else begin
            count <= count + 3'd1;
          end
        end
        RESPOND: begin
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEMORY_RESPONDER_PERF_EN
  logic accept;
  assign accept = (state == IDLE) && (i_request || d_request);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_i_count     <= '0;
      perf_d_count     <= '0;
      perf_busy_cycles <= '0;
    end else begin
      if (accept && !pick_d && perf_i_count != 32'hFFFF_FFFF)
        perf_i_count <= perf_i_count + 32'd1;
      if (accept && pick_d && perf_d_count != 32'hFFFF_FFFF)
        perf_d_count <= perf_d_count + 32'd1;
      if (state != IDLE && perf_busy_cycles != 32'hFFFF_FFFF)
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
    end
  end
`else
  assign perf_i_count     = '0;
  assign perf_d_count     = '0;
  assign perf_busy_cycles = '0;
`endif

endmodule

// File: tb/tb_unified_memory_responder.sv
// Scoreboard bench for unified_memory_responder: expected responses are queued at issue and
// popped by a monitor on each ready pulse; scenario tasks check timing and side effects inline.
module tb_unified_memory_responder;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 16384;
  localparam int AW      = $clog2(DEPTH);
`ifdef MEMORY_RESPONDER_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_request = 1'b0;
  logic [31:0] i_address = '0;
  logic [31:0] i_read_data;
  logic        i_ready;
  logic        d_request = 1'b0;
  logic [31:0] d_address = '0;
  logic        d_write_enable = 1'b0;
  logic [3:0]  d_byte_enable = '0;
  logic [31:0] d_write_data = '0;
  logic [31:0] d_read_data;
  logic        d_ready;
  logic [31:0] perf_i_count, perf_d_count, perf_busy_cycles;

  unified_memory_responder #(.LATENCY(LATENCY), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_request(i_request), .i_address(i_address), .i_read_data(i_read_data), .i_ready(i_ready),
    .d_request(d_request), .d_address(d_address), .d_write_enable(d_write_enable),
    .d_byte_enable(d_byte_enable), .d_write_data(d_write_data), .d_read_data(d_read_data),
    .d_ready(d_ready), .perf_i_count(perf_i_count), .perf_d_count(perf_d_count),
    .perf_busy_cycles(perf_busy_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic        port;   // 1 = D, 0 = I
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model [int];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && (i_ready || d_ready)) begin
      checks++;
      if (i_ready && d_ready) begin
        fails++;
        $display("FAIL both_ready: i_ready=%0b d_ready=%0b required one-hot", i_ready, d_ready);
      end
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ready: i_ready=%0b d_ready=%0b required none", i_ready, d_ready);
      end else begin
        mon_e = sb.pop_front();
        if (d_ready !== mon_e.port) begin
          fails++;
          $display("FAIL sb_port: got d=%0b required d=%0b", d_ready, mon_e.port);
        end
        checks++;
        if ((d_ready ? d_read_data : i_read_data) !== mon_e.data) begin
          fails++;
          $display("FAIL sb_data: got %h required %h", d_ready ? d_read_data : i_read_data,
                   mon_e.data);
        end
      end
    end
  end

  // Issue one transaction from IDLE (call at posedge+#1); lat = cycles to ready, -1 on timeout.
  task automatic run_txn(input bit port, input logic [31:0] addr, input bit we,
                         input logic [3:0] be, input logic [31:0] wd, input bit keep,
                         output int lat);
    int   idx;
    int   c0;
    exp_t e;
    idx = int'(addr[AW+1:2]);
    e.port = port;
    if (port) begin
      if (we) model[idx] = merge(model.exists(idx) ? model[idx] : 32'h0, be, wd);
      e.data = model.exists(idx) ? model[idx] : 32'h0;
      d_address = addr; d_write_enable = we; d_byte_enable = be; d_write_data = wd;
      d_request = 1'b1;
    end else begin
      e.data = model.exists(idx) ? model[idx] : 32'h0;
      i_address = addr;
      i_request = 1'b1;
    end
    sb.push_back(e);
    c0  = cyc;
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if ((port ? d_ready : i_ready) === 1'b1) begin
        lat = cyc - c0;
        break;
      end
    end
    @(posedge clk); #1;
    if (!keep) begin
      if (port) d_request = 1'b0; else i_request = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({i_ready, d_ready} !== 2'b00) begin
      fails++; $display("FAIL reset_ready: got %b required 00", {i_ready, d_ready});
    end
    checks++;
    if (i_read_data !== 32'h0 || d_read_data !== 32'h0) begin
      fails++; $display("FAIL reset_rdata: got i=%h d=%h required 0", i_read_data, d_read_data);
    end
    checks++;
    if (perf_i_count !== 32'h0 || perf_d_count !== 32'h0 || perf_busy_cycles !== 32'h0) begin
      fails++;
      $display("FAIL reset_perf: got %h %h %h required 0", perf_i_count, perf_d_count,
               perf_busy_cycles);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_read();
    int lat;
    run_txn(1'b1, 32'h100, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, lat);
    run_txn(1'b0, 32'h100, 1'b0, 4'h0, 32'h0, 1'b0, lat);
    checks++;
    if (lat !== LATENCY + 1) begin
      fails++; $display("FAIL read_latency: got %0d required %0d", lat, LATENCY + 1);
    end
    @(negedge clk);
    checks++;
    if (i_ready !== 1'b0) begin
      fails++; $display("FAIL read_single_pulse: got i_ready=%b required 0", i_ready);
    end
    checks++;
    if (i_read_data !== 32'hDEADBEEF) begin
      fails++; $display("FAIL read_hold: got %h required deadbeef", i_read_data);
    end
    @(posedge clk); #1;
    // Wrapped upper bits and a nonzero byte offset alias the same word.
    run_txn(1'b0, 32'h0001_0103, 1'b0, 4'h0, 32'h0, 1'b0, lat);
  endtask

  task automatic test_partial_write();
    int lat;
    run_txn(1'b1, 32'h40, 1'b1, 4'hF, 32'h11223344, 1'b0, lat);
    run_txn(1'b1, 32'h40, 1'b1, 4'b0101, 32'hAABBCCDD, 1'b0, lat);
    checks++;
    if (lat !== LATENCY + 1) begin
      fails++; $display("FAIL write_latency: got %0d required %0d", lat, LATENCY + 1);
    end
    checks++;
    if (model[int'(32'h40 >> 2)] !== 32'h11BB33DD) begin
      fails++; $display("FAIL write_model: got %h required 11bb33dd", model[int'(32'h40 >> 2)]);
    end
    run_txn(1'b1, 32'h40, 1'b0, 4'h0, 32'h0, 1'b0, lat);
    run_txn(1'b0, 32'h40, 1'b0, 4'h0, 32'h0, 1'b0, lat);
  endtask

  task automatic test_contention();
    exp_t e;
    bit   ports[4];
    int   times[4];
    int   n;
    pulse_reset();
    i_address = 32'h100; d_address = 32'h40; d_write_enable = 1'b0; d_byte_enable = 4'h0;
    for (int k = 0; k < 4; k++) begin
      e.port = k[0];
      e.data = k[0] ? model[int'(32'h40 >> 2)] : model[int'(32'h100 >> 2)];
      sb.push_back(e);
    end
    i_request = 1'b1; d_request = 1'b1;
    n = 0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge clk);
      if (i_ready || d_ready) begin
        ports[n] = d_ready; times[n] = cyc; n++;
      end
    end
    @(posedge clk); #1;
    i_request = 1'b0; d_request = 1'b0;
    checks++;
    if (n != 4) begin
      fails++; $display("FAIL contention_count: got %0d required 4", n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (ports[k] !== k[0]) begin
        fails++; $display("FAIL contention_order[%0d]: got d=%0b required d=%0b", k, ports[k], k[0]);
      end
      if (k > 0) begin
        checks++;
        if (times[k] - times[k-1] != LATENCY + 2) begin
          fails++;
          $display("FAIL contention_spacing[%0d]: got %0d required %0d", k,
                   times[k] - times[k-1], LATENCY + 2);
        end
      end
    end
    checks++;
    if (perf_d_count !== (PERF ? 32'd2 : 32'd0)) begin
      fails++; $display("FAIL contention_perf_d: got %0d required %0d", perf_d_count, PERF ? 2 : 0);
    end
  endtask

  task automatic test_abort();
    int lat;
    bit seen;
    run_txn(1'b1, 32'h80, 1'b1, 4'hF, 32'h12345678, 1'b0, lat);
    d_address = 32'h80; d_write_enable = 1'b1; d_byte_enable = 4'hF; d_write_data = 32'hFFFFFFFF;
    d_request = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; d_request = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({i_ready, d_ready} !== 2'b00 || i_read_data !== 32'h0 || d_read_data !== 32'h0) begin
      fails++;
      $display("FAIL abort_outputs: got rdy=%b i=%h d=%h required 0", {i_ready, d_ready},
               i_read_data, d_read_data);
    end
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (d_ready || i_ready) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      fails++; $display("FAIL abort_no_ready: got ready pulse required none");
    end
    @(posedge clk); #1;
    run_txn(1'b1, 32'h80, 1'b0, 4'h0, 32'h0, 1'b0, lat);
  endtask

  task automatic test_burst();
    int lat;
    for (int k = 0; k < 4; k++) run_txn(1'b1, 32'(4*k), 1'b1, 4'hF, 32'hA5000000 + 32'(k), 1'b0, lat);
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      run_txn(1'b0, 32'(4*k), 1'b0, 4'h0, 32'h0, 1'b1, lat);
      checks++;
      if (lat !== LATENCY + 1) begin
        fails++; $display("FAIL burst_latency[%0d]: got %0d required %0d", k, lat, LATENCY + 1);
      end
    end
    i_request = 1'b0;
    @(negedge clk);
    checks++;
    if (perf_i_count !== (PERF ? 32'd4 : 32'd0)) begin
      fails++; $display("FAIL burst_perf_i: got %0d required %0d", perf_i_count, PERF ? 4 : 0);
    end
    checks++;
    if (perf_busy_cycles !== (PERF ? 32'(4 * (LATENCY + 1)) : 32'd0)) begin
      fails++;
      $display("FAIL burst_perf_busy: got %0d required %0d", perf_busy_cycles,
               PERF ? 4 * (LATENCY + 1) : 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_read();
    test_partial_write();
    test_contention();
    test_abort();
    test_burst();
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL sb_leftover: got %0d pending required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/unified_memory_responder.md
UNIFIED_MEMORY_RESPONDER -- requirements
Module: unified_memory_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, giving wait cycles between accept and ready (legal 1..7).
REQ-002 SHALL have parameter DEPTH_WORDS, default 16384, giving backing-store size in 32-bit words (power of two).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_request  input  1  instruction-side request, held by requester.
REQ-006 SHALL have port i_address  input  32  instruction-side byte address.
REQ-007 SHALL have port i_read_data  output  32  instruction-side read word.
REQ-008 SHALL have port i_ready  output  1  instruction-side one-cycle completion pulse.
REQ-009 SHALL have port d_request  input  1  data-side request, held by requester.
REQ-010 SHALL have port d_address  input  32  data-side byte address.
REQ-011 SHALL have port d_write_enable  input  1  data-side write (1) or read (0).
REQ-012 SHALL have port d_byte_enable  input  4  data-side write lane mask, bit n = byte n.
REQ-013 SHALL have port d_write_data  input  32  data-side write word.
REQ-014 SHALL have port d_read_data  output  32  data-side read word.
REQ-015 SHALL have port d_ready  output  1  data-side one-cycle completion pulse.
REQ-016 SHALL have ports perf_i_count, perf_d_count, perf_busy_cycles  output  32 each  performance counters (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESPOND over a single internal word array indexed by address[log2(DEPTH_WORDS)+1:2]; upper bits ignored (wrap), address[1:0] ignored.
REQ-018 IDLE: on a cycle with any request high, SHALL accept one port, latch its address/write_enable/byte_enable/write_data, load wait counter to 0, go WAIT.
REQ-019 Arbitration SHALL be round-robin: single requester wins; both requesting -> port not granted last wins; first tie after reset goes to I port.
REQ-020 WAIT: counter increments each cycle; when counter equals LATENCY-1 SHALL go RESPOND.
REQ-021 RESPOND: SHALL assert the granted port's ready for exactly one cycle with read_data valid that same cycle, then return to IDLE.
REQ-022 Accept at cycle T SHALL yield ready at cycle T+LATENCY+1; next accept earliest at T+LATENCY+2.
REQ-023 D writes SHALL update only enabled byte lanes on the edge entering RESPOND; d_read_data during that ready cycle SHALL be the post-write word.
REQ-024 I port SHALL be read-only; the ungranted port's ready SHALL stay 0 and its request SHALL remain pending.
REQ-025 Requester inputs SHALL be sampled only at accept; a request dropped or address changed before ready SHALL NOT abort the transaction (ready still pulses, write still commits).
REQ-026 Requester holding request high after ready with a new address SHALL be served as a new transaction (line-fill bursts).
REQ-027 read_data outputs SHALL hold last value outside ready cycles.

Reset
REQ-028 rst high SHALL force state IDLE, counter 0, i_ready=0, d_ready=0, i_read_data=0, d_read_data=0, last-grant=D, perf counters 0, from the next edge.
REQ-029 Reset mid-transaction SHALL discard it without ready; a pending write not yet committed SHALL NOT commit; array contents SHALL NOT be cleared.

Configuration
REQ-030 With MEMORY_RESPONDER_PERF_EN defined: perf_i_count/perf_d_count SHALL increment per accepted I/D transaction, perf_busy_cycles per cycle state != IDLE; all saturate at 32'hFFFFFFFF.
REQ-031 Without MEMORY_RESPONDER_PERF_EN: all perf outputs SHALL be constant 0 and no counter registers synthesized.

Verification
REQ-032 Read: preload word 0x100 = 0xDEADBEEF, i_request with i_address 0x100 at cycle T, LATENCY=2 -> i_ready=1, i_read_data=0xDEADBEEF at T+3 only.
REQ-033 Partial write: word 0x40 = 0x11223344, d write be=4'b0101 data 0xAABBCCDD -> d_ready with d_read_data 0x11BB33DD; later read returns same.
REQ-034 Contention: both requests held from cycle after reset -> grants I, D, I, D alternate; ready pulses spaced LATENCY+2 cycles.
REQ-035 Abort: assert rst during WAIT of a write to 0x80 -> no d_ready, word 0x80 unchanged, outputs 0 next cycle.
REQ-036 Burst: i_request held, address stepping 0x0,0x4,0x8,0xC after each ready -> four ready pulses, correct words, perf_i_count=4 with macro, 0 without.
